// File: rtl/xnor_pop_pkg.sv
// Shared types and helpers for the streaming XNOR-popcount accumulator.
// Mode encodings, majority-of-three, and count-width sizing.
package xnor_pop_pkg;

    localparam logic MODE_XNOR = 1'b0;
    localparam logic MODE_MAJ  = 1'b1;

    typedef enum logic {
        V_IDLE = 1'b0,
        V_ACC  = 1'b1
    } vec_state_t;

    function automatic logic maj3(
        input logic x0,
        input logic x1,
        input logic x2
    );
        return (x0 & x1) | (x0 & x2) | (x1 & x2);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xnor_pop_chunk.sv
// Combinational per-beat counter: XNOR popcount, or popcount of
// majority-of-three over consecutive XNOR bit triples.
module xnor_pop_chunk
    import xnor_pop_pkg::*;
#(
    parameter int CHUNK = 576
) (
    input  logic [CHUNK-1:0]           a,
    input  logic [CHUNK-1:0]           w,
    input  logic                       maj,
    output logic [$clog2(CHUNK+1)-1:0] count
);

    localparam int CW = $clog2(CHUNK + 1);

    logic [CHUNK-1:0] x;

    assign x = a ~^ w;

    always_comb begin
        count = '0;
        if (maj == MODE_MAJ) begin
            for (int g = 0; g < CHUNK / 3; g++) begin
                count = count + CW'(maj3(x[3*g], x[3*g+1], x[3*g+2]));
            end
        end else begin
            for (int i = 0; i < CHUNK; i++) begin
                count = count + CW'(x[i]);
            end
        end
    end

endmodule

// File: rtl/xnor_pop_acc.sv
// Streaming two-stage XNOR/majority popcount accumulator with valid/ready.
// Define XNORPOP_THRESH_EN to enable the out_bit threshold comparator.
module xnor_pop_acc
    import xnor_pop_pkg::*;
#(
    parameter int CHUNK     = 576,
    parameter int BEATS_MAX = 8,
    parameter int ACC_W     = $clog2(CHUNK * BEATS_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHUNK-1:0] in_a,
    input  logic [CHUNK-1:0] in_w,
    input  logic             in_last,
    input  logic             in_maj,
    input  logic [ACC_W-1:0] in_thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_pop,
    output logic             out_err,
    output logic             out_bit
);

    localparam int CW = cnt_w(CHUNK);
    localparam int BW = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
    localparam logic [BW-1:0] BEAT_END = BW'(BEATS_MAX - 1);

    logic [BW-1:0]    bcnt;
    vec_state_t       vstate;
    logic             first;
    logic             forced;
    logic             last_eff;
    logic             maj_eff;
    logic             accept;
    logic [CW-1:0]    beat_cnt;

    logic             s1_valid;
    logic             s1_last;
    logic             s1_first;
    logic             s1_err;
    logic             s1_maj;
    logic [CW-1:0]    s1_cnt;
    logic             s1_adv;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] pop_q;
    logic             valid_q;
    logic             err_q;

    assign vstate   = (bcnt == '0) ? V_IDLE : V_ACC;
    assign first    = (vstate == V_IDLE);
    assign forced   = (bcnt == BEAT_END);
    assign last_eff = in_last || forced;

    // Within a vector the S1 mode flag still holds the vector's mode.
    assign maj_eff  = first ? in_maj : s1_maj;

    assign s1_adv   = s1_valid && (!s1_last || !valid_q || out_ready);
    assign in_ready = rst_n && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;

    assign sum = (s1_first ? '0 : acc) + ACC_W'(s1_cnt);

    xnor_pop_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (in_a),
        .w     (in_w),
        .maj   (maj_eff),
        .count (beat_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
        end else if (accept) begin
            bcnt <= last_eff ? '0 : bcnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            s1_err   <= 1'b0;
            s1_maj   <= MODE_XNOR;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_cnt   <= beat_cnt;
            s1_last  <= last_eff;
            s1_first <= first;
            s1_err   <= forced && !in_last;
            s1_maj   <= maj_eff;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pop_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                acc <= sum;
            end
            if (s1_adv && s1_last) begin
                pop_q   <= sum;
                err_q   <= s1_err;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_pop   = pop_q;
    assign out_err   = err_q;

`ifdef XNORPOP_THRESH_EN
    logic [ACC_W-1:0] s1_thresh;
    logic [ACC_W-1:0] thr_eff;
    logic             bit_q;

    assign thr_eff = first ? in_thresh : s1_thresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_thresh <= '0;
            bit_q     <= 1'b0;
        end else begin
            if (accept) begin
                s1_thresh <= thr_eff;
            end
            if (s1_adv && s1_last) begin
                bit_q <= (sum >= s1_thresh);
            end
        end
    end

    assign out_bit = bit_q;
`else
    logic unused_thresh;

    assign unused_thresh = ^in_thresh;
    assign out_bit       = 1'b0;
`endif

endmodule

// File: doc/xnor_pop_acc.md
# xnor_pop_acc

Streaming, pipelined successor to the combinational XNOR-popcount cell. Accumulates XNOR (or 3-input-majority-of-XNOR) popcounts over a vector delivered as 1..BEATS_MAX beats of CHUNK bits each. Emits one full-precision count per vector through a valid/ready handshake. Sits between the activation/weight fetch streams and the binarised-activation stage of a MajorityNet layer.

## Interface
- CHUNK, 576, bits per beat; must be a multiple of 3.
- BEATS_MAX, 8, maximum beats per vector.
- ACC_W, $clog2(CHUNK*BEATS_MAX+1), accumulator/result width; sized so a full match never wraps.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_a  in  CHUNK  activation bits.
- in_w  in  CHUNK  weight bits.
- in_last  in  1  final beat of the vector.
- in_maj  in  1  0 = plain XNOR popcount, 1 = majority mode; sampled on the first beat of a vector only.
- in_thresh  in  ACC_W  compare threshold; sampled on the first beat of a vector.
- out_valid  out  1  result held until out_ready.
- out_ready  in  1  consumer accepts.
- out_pop  out  ACC_W  vector count.
- out_err  out  1  vector closed by BEATS_MAX rather than in_last.
- out_bit  out  1  binarised result; see Configuration.

## Operation
- Beat count, mode 0: number of ones in in_a ~^ in_w, range 0..CHUNK.
- Beat count, mode 1: for each group g = 0..CHUNK/3-1, compute maj3 of XNOR bits 3g, 3g+1 and 3g+2, then count the ones. Range 0..CHUNK/3.
- Stage S1 registers: beat count, last, first, mode flag. Per-vector mode and threshold are latched on the first beat; later changes of in_maj or in_thresh inside a vector are ignored.
- Stage S2 is the accumulator.
  - A first beat loads the accumulator with its count (no separate clear cycle).
  - Other beats add their count.
  - A last beat writes accumulator + count into the result register and sets out_valid.
- Beat counter 0..BEATS_MAX-1 counts accepted beats in the current vector.
  - The BEATS_MAX-th beat is forced last.
  - If that beat lacks in_last, out_err=1 for that result.
  - The next accepted beat starts a new vector. A stray in_last on it is honoured normally.
- Vector state, derived from the beat counter: IDLE (count 0, next beat is first) → ACC (count >0) → IDLE on last/forced-last.
- Arithmetic is unsigned and zero-extended to ACC_W. No saturation is needed by construction.

## Timing
- Reset: in_ready=0 while rst_n=0 and 1 in the first cycle after release. out_valid, out_pop, out_err, out_bit and all internal state are 0.
- Reset asserted mid-vector discards the partial vector and any pending result.
- Throughput: one beat per cycle. Back-to-back vectors have no bubble; a single-beat vector every cycle is sustained while out_ready=1.
- Latency: last beat accepted in cycle t → out_valid high in cycle t+2.
- Backpressure rules:
  - A last beat in S1 stalls while out_valid && !out_ready.
  - in_ready = !s1_valid || s1_advances.
  - Non-last beats never stall.
- Simultaneous events: when out_ready is accepted in the same cycle that S1 holds a last beat, the new result replaces the old one in that cycle with no gap.
- out_pop, out_err and out_bit stay stable while out_valid && !out_ready.

## Configuration
- XNORPOP_THRESH_EN defined:
  - out_bit = (out_pop >= latched in_thresh), registered alongside out_pop.
  - The comparator sits in S2 on the accumulator + count sum.
- Macro undefined:
  - The comparator and threshold latch are removed, and out_bit is tied to 0.
  - The port list is unchanged, so instantiation is identical either way.

## Structure
- Package xnor_pop_pkg:
  - mode constants MODE_XNOR=0, MODE_MAJ=1;
  - maj3 function;
  - width helper function for count widths (clog2(n+1)).
- Sub-module xnor_pop_chunk: combinational per-beat counter.
  - Parameter CHUNK; inputs a, w, maj; output count of $clog2(CHUNK+1) bits.
  - Instantiated once, feeding S1.
- Top level holds S1, S2, the beat counter, the handshake and the optional comparator.

## Test plan
Bench configuration: CHUNK=9, BEATS_MAX=4, ACC_W=6.
- Mode 0, a=w=9'h1FF, 3 beats with last on beat 3 → out_pop=27 and out_err=0; out_valid rises 2 cycles after beat 3.
- One beat, last, a=9'h1FF, w=9'b110_100_000 → mode 0 gives out_pop=3; mode 1 gives out_pop=1. Toggling in_maj on beat 2 of a 2-beat vector changes nothing.
- out_ready held low for 5 cycles while three 1-beat vectors stream → in_ready drops while the second last-beat is blocked. Results arrive in order with no loss or duplication.
- 4 beats of all-match with no in_last → out_pop=36 and out_err=1. The following 1-beat vector gives 9 with out_err=0.
- rst_n pulsed low after 2 beats of a vector → all outputs read 0. A fresh 1-beat all-match vector then gives out_pop=9.
- With XNORPOP_THRESH_EN, in_thresh=20: 2-beat all-match vector (18) → out_bit=0; 3-beat (27) → out_bit=1. Undefined macro → out_bit=0 always.
